// File: rtl/i2c_pkg.sv
// Shared state encoding and bus constants for the I2C target core.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic RW_READ = 1'b1;
    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam int   ADDR_W  = 7;
    localparam int   BYTE_W  = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the asynchronous SCL/SDA bus levels and derives edge, START and STOP events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;

    // Reset to the idle bus level so leaving reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync[0] <= scl_i;
            sda_sync[0] <= sda_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_hist <= scl_s;
            sda_hist <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist;
    assign scl_fall = ~scl_s & scl_hist;
    // SDA may only move while SCL is low, except for START/STOP; require SCL high on both samples.
    assign start    = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop     = scl_s & scl_hist & ~sda_hist & sda_s;

endmodule

// File: rtl/i2c_target_core.sv
// I2C target with a 7-bit address: writes surface on data_o, reads pull bytes from a valid/ready producer.
module i2c_target_core
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDRESS = 7'h21,
    parameter int                SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_o,
    output logic              sda_o,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              data_i_valid,
    output logic              data_i_ready,
    output logic [BYTE_W-1:0] data_o,
    output logic              data_o_valid
);

    logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_s   (scl_s),
        .sda_s   (sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    i2c_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              sda_q, sda_d;
    logic              scl_q, scl_d;
    logic [BYTE_W-1:0] data_o_q, data_o_d;
    logic              vld_q, vld_d;
    logic              load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
            data_o_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sda_q    <= sda_d;
            scl_q    <= scl_d;
            data_o_q <= data_o_d;
            vld_q    <= vld_d;
        end
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        sda_d    = sda_q;
        scl_d    = scl_q;
        data_o_d = data_o_q;
        vld_d    = 1'b0;
        load     = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            sda_d   = 1'b1;
            scl_d   = 1'b1;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            sda_d   = 1'b1;
            scl_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[BYTE_W-2:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = '0;
                            state_d = (shreg_q[ADDR_W-1:0] == SLAVE_ADDRESS) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                // cnt_q marks whether the ACK bit is already being driven; the R/W bit stays in shreg_q[0].
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            sda_d = ACK;
                            cnt_d = 4'd1;
                        end else begin
                            sda_d = 1'b1;
                            cnt_d = '0;
                            if (state_q == ADDR_ACK && shreg_q[0] == RW_READ)
                                state_d = RD_LOAD;
                            else
                                state_d = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[BYTE_W-2:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d    = '0;
                            data_o_d = {shreg_q[BYTE_W-2:0], sda_s};
                            vld_d    = 1'b1;
                            state_d  = WR_ACK;
                        end
                    end
                end
                // Stretch SCL until the producer has a byte; the MSB goes out as soon as it is latched.
                RD_LOAD: begin
                    if (data_i_valid && !scl_s) begin
                        load    = 1'b1;
                        shreg_d = data_i;
                        sda_d   = data_i[BYTE_W-1];
                        scl_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = RD_DATA;
                    end else begin
                        scl_d = 1'b0;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            sda_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = RD_ACK;
                        end else begin
                            shreg_d = {shreg_q[BYTE_W-2:0], shreg_q[BYTE_W-1]};
                            sda_d   = shreg_q[BYTE_W-2];
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK)
                            state_d = WAIT_STOP;
                        else
                            cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = '0;
                        state_d = RD_LOAD;
                    end
                end
                WAIT_STOP: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign scl_o        = scl_q;
    assign sda_o        = sda_q;
    assign data_o       = data_o_q;
    assign data_o_valid = vld_q;
    assign data_i_ready = load & ~rst;

endmodule

// File: tb/tb_i2c_target_core.sv
// Bit-banged I2C master driving the target over a wired-AND bus, checked against a queue-based transfer model.
module tb_i2c_target_core;

    localparam int         HALF = 100;
    localparam logic [6:0] TGT  = 7'h21;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       scl_i, sda_i, scl_o, sda_o;
    logic [7:0] data_i, data_o;
    logic       data_i_valid, data_i_ready, data_o_valid;

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_core dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_o       (scl_o),
        .sda_o       (sda_o),
        .data_i      (data_i),
        .data_i_valid(data_i_valid),
        .data_i_ready(data_i_ready),
        .data_o      (data_o),
        .data_o_valid(data_o_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Received-byte monitor
    logic [7:0] got_q[$];
    logic [7:0] exp_wr[$];
    int         vld_run   = 0;
    int         vld_multi = 0;
    initial forever begin
        @(negedge clk);
        if (data_o_valid === 1'b1) begin
            got_q.push_back(data_o);
            vld_run++;
            if (vld_run > 1) vld_multi++;
        end else begin
            vld_run = 0;
        end
    end

    // Producer: presents queue head; after each consumed byte, valid drops for 2 clk
    logic [7:0] prod_q[$];
    bit         prod_en   = 1'b1;
    bit         consumed  = 1'b0;
    int         hold      = 0;
    int         ready_cnt = 0;
    int         ready_bad = 0;
    initial begin
        data_i       = 8'h00;
        data_i_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (consumed) begin
                prod_q.delete(0);
                consumed = 1'b0;
                hold     = 2;
            end else if (hold > 0) begin
                hold--;
            end
            data_i_valid = prod_en && prod_q.size() > 0 && hold == 0;
            data_i       = (prod_q.size() > 0) ? prod_q[0] : 8'h00;
        end
    end
    initial forever begin
        @(negedge clk);
        if (data_i_ready === 1'b1) begin
            ready_cnt++;
            if (data_i_valid !== 1'b1) ready_bad++;
            consumed = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int n = 0;
        scl_m = 1'b1;
        while (scl_i !== 1'b1 && n < 5000) begin
            wclk(1);
            n++;
        end
        if (n >= 5000) check("scl_release_bound", {31'b0, scl_i}, 32'd1);
    endtask

    task automatic send_bit(input logic b, output logic seen);
        sda_m = b;
        wclk(HALF);
        scl_up();
        wclk(HALF / 2);
        seen = sda_i;
        wclk(HALF / 2);
        scl_m = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wclk(HALF);
        scl_up();
        wclk(HALF);
        sda_m = 1'b0;
        wclk(HALF);
        scl_m = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wclk(HALF);
        scl_up();
        wclk(HALF);
        sda_m = 1'b1;
        wclk(HALF);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(mack, s);
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_wr[i]);
        got_q.delete();
        exp_wr.delete();
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] b0, b1, wb;
        logic [6:0] a;
        int         r0, n;

        scl_m = 1'b1;
        sda_m = 1'b1;
        rst   = 1'b1;
        wclk(5);
        check("rst_scl_o", scl_o, 1'b1);
        check("rst_sda_o", sda_o, 1'b1);
        check("rst_data_o", data_o, 8'h00);
        check("rst_data_o_valid", data_o_valid, 1'b0);
        check("rst_data_i_ready", data_i_ready, 1'b0);
        rst = 1'b0;
        wclk(5);

        // Single-byte write
        i2c_start();
        write_byte({TGT, 1'b0}, ack);
        check("w1_addr_ack", ack, 1'b0);
        write_byte(8'h5A, ack);
        check("w1_data_ack", ack, 1'b0);
        exp_wr.push_back(8'h5A);
        i2c_stop();
        cmp_writes("w1");

        // Four-byte write
        i2c_start();
        write_byte({TGT, 1'b0}, ack);
        check("w4_addr_ack", ack, 1'b0);
        foreach (b0[i]) ;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: wb = 8'h5A;
                1: wb = 8'h33;
                2: wb = 8'h7E;
                default: wb = 8'h1A;
            endcase
            write_byte(wb, ack);
            check("w4_data_ack", ack, 1'b0);
            exp_wr.push_back(wb);
        end
        i2c_stop();
        cmp_writes("w4");

        // Single-byte read, master NACKs
        prod_q.push_back(8'h81);
        wclk(4);
        r0 = ready_cnt;
        i2c_start();
        write_byte({TGT, 1'b1}, ack);
        check("r1_addr_ack", ack, 1'b0);
        read_byte(1'b1, b0);
        check("r1_byte", b0, 8'h81);
        wclk(4);
        check("r1_sda_released", sda_o, 1'b1);
        i2c_stop();
        check("r1_ready_pulses", ready_cnt - r0, 1);

        // Two-byte read
        prod_q.push_back(8'h81);
        prod_q.push_back(8'h5A);
        wclk(4);
        r0 = ready_cnt;
        i2c_start();
        write_byte({TGT, 1'b1}, ack);
        check("r2_addr_ack", ack, 1'b0);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        i2c_stop();
        check("r2_byte0", b0, 8'h81);
        check("r2_byte1", b1, 8'h5A);
        check("r2_ready_pulses", ready_cnt - r0, 2);

        // Wrong address, then a good transfer
        i2c_start();
        write_byte({7'h22, 1'b0}, ack);
        check("wa_addr_nack", ack, 1'b1);
        write_byte(8'hC3, ack);
        check("wa_data_nack", ack, 1'b1);
        i2c_stop();
        i2c_start();
        write_byte({TGT, 1'b0}, ack);
        check("wa_next_addr_ack", ack, 1'b0);
        write_byte(8'h96, ack);
        check("wa_next_data_ack", ack, 1'b0);
        exp_wr.push_back(8'h96);
        i2c_stop();
        cmp_writes("wa");

        // Clock stretch while the producer has nothing
        prod_en = 1'b0;
        prod_q.push_back(8'hA7);
        r0 = ready_cnt;
        fork
            begin
                i2c_start();
                write_byte({TGT, 1'b1}, ack);
                check("st_addr_ack", ack, 1'b0);
                read_byte(1'b1, b0);
                i2c_stop();
            end
            begin
                n = 0;
                while (scl_o !== 1'b0 && n < 20000) begin
                    wclk(1);
                    n++;
                end
                check("st_stretch_seen", scl_o, 1'b0);
                wclk(50);
                check("st_stretch_held", scl_o, 1'b0);
                check("st_no_ready", data_i_ready, 1'b0);
                prod_en = 1'b1;
            end
        join
        check("st_byte", b0, 8'hA7);
        check("st_ready_pulses", ready_cnt - r0, 1);

        // Reset while the target drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            wb = {TGT, 1'b0};
            send_bit(wb[i], s);
        end
        wclk(10);
        check("rs_ack_driven", sda_o, 1'b0);
        rst = 1'b1;
        wclk(1);
        check("rs_sda_o", sda_o, 1'b1);
        check("rs_scl_o", scl_o, 1'b1);
        rst = 1'b0;
        send_bit(1'b1, s);
        check("rs_ack_dropped", s, 1'b1);
        write_byte({TGT, 1'b0}, ack);
        check("rs_idle_ignores", ack, 1'b1);
        i2c_stop();
        cmp_writes("rs");

        // Randomized writes
        for (int t = 0; t < 2; t++) begin
            a = ($urandom_range(0, 1) == 1) ? TGT : 7'($urandom_range(0, 127));
            i2c_start();
            write_byte({a, 1'b0}, ack);
            check("rnd_addr_ack", ack, (a == TGT) ? 1'b0 : 1'b1);
            for (int k = 0; k < 2; k++) begin
                wb = 8'($urandom);
                write_byte(wb, ack);
                check("rnd_data_ack", ack, (a == TGT) ? 1'b0 : 1'b1);
                if (a == TGT) exp_wr.push_back(wb);
            end
            i2c_stop();
            cmp_writes("rnd_w");
        end

        // Randomized read
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        prod_q.push_back(b0);
        prod_q.push_back(b1);
        wclk(4);
        r0 = ready_cnt;
        i2c_start();
        write_byte({TGT, 1'b1}, ack);
        check("rnd_r_addr_ack", ack, 1'b0);
        read_byte(1'b0, wb);
        check("rnd_r_byte0", wb, b0);
        read_byte(1'b1, wb);
        check("rnd_r_byte1", wb, b1);
        i2c_stop();
        check("rnd_r_ready_pulses", ready_cnt - r0, 2);

        check("vld_single_cycle", vld_multi, 0);
        check("ready_without_valid", ready_bad, 0);
        check("no_stray_writes", got_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_core.md
Name: i2c_target_core

Overview:
- I2C target (slave) block with a 7-bit address. Supports standard write and read transfers from an external open-drain bus master.
- Received write bytes appear on a byte-wide output with a one-cycle valid strobe.
- Read bytes are pulled from a local producer through a valid/ready handshake.
- Sits between the board-level open-drain pads (scl/sda wired-AND) and the local register/FIFO logic.

Parameters:
- SLAVE_ADDRESS, 7'h21, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- scl_i  in  1  resolved SCL bus level (asynchronous).
- sda_i  in  1  resolved SDA bus level (asynchronous).
- scl_o  out  1  open-drain SCL drive; 0 pulls low (clock stretch), 1 releases.
- sda_o  out  1  open-drain SDA drive; 0 pulls low, 1 releases.
- data_i  in  8  next byte to transmit on a read.
- data_i_valid  in  1  data_i holds a valid byte.
- data_i_ready  out  1  one-cycle pulse: data_i latched into the transmit shift register this cycle.
- data_o  out  8  last byte received in a write.
- data_o_valid  out  1  one-cycle pulse: data_o holds a new received byte.

Behaviour:
- Reset values: scl_o=1, sda_o=1, data_o=8'h00, data_o_valid=0, data_i_ready=0, state IDLE, bit counter 0.
- Input conditioning: scl_i/sda_i pass through SYNC_STAGES flops plus one history flop. Edge detection on the synchronized signals gives scl_rise, scl_fall, start, stop.
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
- START or STOP is recognised in any state, including mid-byte. Each overrides the current state.
  - START (including repeated START) -> ADDR with the bit counter cleared.
  - STOP -> IDLE, with sda_o and scl_o released.
- Bus timing: bits arrive MSB first, sampled on scl_rise. The design supports SCL high/low phases of ≥ 8 clk; the bench uses ~100 clk per phase.
- SDA changes from the target are made within 2 clk after scl_fall and held until the next scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th scl_rise, compare address to SLAVE_ADDRESS.
    - Match: go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP, never driving SDA.
  - ADDR_ACK: drive sda_o=0 from the scl_fall after bit 8 until the scl_fall after bit 9.
    - R/W=0 -> WR_DATA.
    - R/W=1 -> RD_LOAD.
  - WR_DATA: shift 8 bits. On the 8th scl_rise, update data_o and pulse data_o_valid for exactly one clk, then go to WR_ACK.
  - WR_ACK: drive ACK as in ADDR_ACK (always ACK, no backpressure), then return to WR_DATA.
  - RD_LOAD (entered while SCL is low after the ACK falling edge):
    - If data_i_valid=1: latch data_i, pulse data_i_ready for one clk, go to RD_DATA.
    - Otherwise: hold scl_o=0 (clock stretch) until data_i_valid=1, then latch, pulse, and release scl_o.
  - RD_DATA: drive shift register MSB on sda_o; shift on each scl_fall. After the 8th bit's scl_fall, release sda_o and go to RD_ACK.
  - RD_ACK: sample sda on scl_rise.
    - 0 (ACK) -> RD_LOAD at the next scl_fall.
    - 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- data_i_ready never pulses without data_i_valid=1 in the same cycle. It pulses at most once per transmitted byte.
- data_o_valid never pulses for address bytes or non-matching transfers.
- Synchronous rst in any state returns all outputs to reset values immediately, including releasing a stretch or ACK.

Decomposition:
- Package i2c_pkg:
  - State enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP).
  - Constants RW_READ=1, ACK=0, NACK=1, ADDR_W=7, BYTE_W=8.
- Sub-module i2c_line_sync:
  - Synchronizers and history flops.
  - Outputs scl_s, sda_s, scl_rise, scl_fall, start, stop.
- Top module holds the FSM, shift register and bit counter.

Test Plan:
- Write 1 byte: START, 0x42 (0x21+W), 0x5A, STOP -> ACK on address and data bits; one data_o_valid pulse with data_o=0x5A.
- Write 4 bytes 0x5A,0x33,0x7E,0x1A -> four single-cycle data_o_valid pulses in that order; all ACKed.
- Read 1 byte (data_i=0x81, valid high): START, 0x43, master NACK, STOP -> master reads 0x81; exactly one data_i_ready pulse; target releases SDA after the NACK.
- Read 2 bytes with producer sequence 0x81 then 0x5A (next byte presented the cycle after ready, valid dropped for 2 clk) -> master ACKs the first, NACKs the second, and reads 0x81, 0x5A.
- Wrong address 0x22 write -> no ACK (SDA stays high on the 9th clock), no data_o_valid; the next correctly addressed transfer works.
- Read with data_i_valid=0 at RD_LOAD -> scl_o held low until valid is asserted 50 clk later, then the byte transfers correctly. Separately, rst asserted mid-byte -> scl_o=1 and sda_o=1 next clk, FSM in IDLE.
